sprite_mover: RTL and testbench

- Parametrised successor of the single-sprite mover used by the VGA games.
- Holds one rectangular object's upper-left position (xl, yt) and moves it by a per-axis speed on each slow tick, under four direction inputs.
- Saturates exactly at programmable bounds and reports per-pixel hit flags for the scan position, for use by the pixel mux.
- Adds the following, which the previous generation lacked: parametrised width and tick rate, respawn, bound flags, and correct up/down sense (up decreases yt).

---
 rtl/sprite_mover.sv | 155 +++++++++++++++
 tb/tb_sprite_mover.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sprite_mover.sv
// sprite_mover: moves one rectangle by per-axis speed on each slow tick, saturating at programmable bounds.
// Optional SPRITE_WRAP_EN: horizontal motion wraps between left_bound and right_bound-xdiff instead of saturating.
module sprite_mover #(
  parameter int COORD_W  = 10,
  parameter int TICK_DIV = 2500000,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               left,
  input  logic               right,
  input  logic               up,
  input  logic               down,
  input  logic               respawn,
  input  logic [COORD_W-1:0] xstart,
  input  logic [COORD_W-1:0] ystart,
  input  logic [COORD_W-1:0] xdiff,
  input  logic [COORD_W-1:0] ydiff,
  input  logic [COORD_W-1:0] xspeed,
  input  logic [COORD_W-1:0] yspeed,
  input  logic [COORD_W-1:0] left_bound,
  input  logic [COORD_W-1:0] right_bound,
  input  logic [COORD_W-1:0] top_bound,
  input  logic [COORD_W-1:0] bottom_bound,
  output logic               objectx,
  output logic               objecty,
  output logic               hit,
  output logic [COORD_W-1:0] xl,
  output logic [COORD_W-1:0] yt,
  output logic               at_left,
  output logic               at_right,
  output logic               at_top,
  output logic               at_bottom
);

  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic [COORD_W-1:0] xl_nxt, yt_nxt;

  // Extended-width terms so that sums and differences never wrap.
  logic [COORD_W:0]   xl_e, yt_e, x_e, y_e;
  logic [COORD_W:0]   lim_x, lim_y, sum_x, sum_y, lo_x, lo_y;
  logic [COORD_W-1:0] dif_x, dif_y;
  logic               in_x, in_y;

  assign xl_e  = {1'b0, xl};
  assign yt_e  = {1'b0, yt};
  assign x_e   = {1'b0, x};
  assign y_e   = {1'b0, y};
  assign lim_x = {1'b0, right_bound} - {1'b0, xdiff};
  assign lim_y = {1'b0, bottom_bound} - {1'b0, ydiff};
  assign sum_x = xl_e + {1'b0, xspeed};
  assign sum_y = yt_e + {1'b0, yspeed};
  assign lo_x  = {1'b0, left_bound} + {1'b0, xspeed};
  assign lo_y  = {1'b0, top_bound} + {1'b0, yspeed};
  assign dif_x = xl - xspeed;
  assign dif_y = yt - yspeed;
  assign in_x  = (xl_e <= x_e) && (x_e < xl_e + {1'b0, xdiff});
  assign in_y  = (yt_e <= y_e) && (y_e < yt_e + {1'b0, ydiff});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_MAX);
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = LOAD;
    xl_nxt    = xl;
    yt_nxt    = yt;
    case (state)
      LOAD: begin
        xl_nxt    = xstart;
        yt_nxt    = ystart;
        state_nxt = RUN;
      end
      RUN: begin
        if (respawn)   state_nxt = LOAD;
        else if (tick) state_nxt = STEP;
        else           state_nxt = RUN;
      end
      STEP: begin
        state_nxt = RUN;
        // A zero speed must hold even when the object already sits beyond a limit.
        if (xspeed != '0) begin
`ifdef SPRITE_WRAP_EN
          if (right && !left)
            xl_nxt = (sum_x > lim_x) ? left_bound : sum_x[COORD_W-1:0];
          else if (left && !right)
            xl_nxt = (xl_e < lo_x) ? lim_x[COORD_W-1:0] : dif_x;
`else
          if (right && !left)
            xl_nxt = (sum_x >= lim_x) ? lim_x[COORD_W-1:0] : sum_x[COORD_W-1:0];
          else if (left && !right)
            xl_nxt = (xl_e < lo_x) ? left_bound : dif_x;
`endif
        end
        if (yspeed != '0) begin
          if (down && !up)
            yt_nxt = (sum_y >= lim_y) ? lim_y[COORD_W-1:0] : sum_y[COORD_W-1:0];
          else if (up && !down)
            yt_nxt = (yt_e < lo_y) ? top_bound : dif_y;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xl        <= '0;
      yt        <= '0;
      at_left   <= 1'b0;
      at_right  <= 1'b0;
      at_top    <= 1'b0;
      at_bottom <= 1'b0;
      objectx   <= 1'b0;
      objecty   <= 1'b0;
      hit       <= 1'b0;
    end else begin
      xl        <= xl_nxt;
      yt        <= yt_nxt;
      at_left   <= (xl_nxt == left_bound);
      at_right  <= ({1'b0, xl_nxt} == lim_x);
      at_top    <= (yt_nxt == top_bound);
      at_bottom <= ({1'b0, yt_nxt} == lim_y);
      if (state == LOAD) begin
        objectx <= 1'b0;
        objecty <= 1'b0;
        hit     <= 1'b0;
      end else begin
        objectx <= in_x;
        objecty <= in_y;
        hit     <= in_x && in_y;
      end
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover with TICK_DIV=4; one vector spans exactly one tick period.
module tb_sprite_mover;

`ifdef SPRITE_WRAP_EN
  localparam bit WR = 1'b1;
`else
  localparam bit WR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x, y, xstart, ystart, xdiff, ydiff, xspeed, yspeed;
  logic [9:0] left_bound, right_bound, top_bound, bottom_bound;
  logic       left, right, up, down, respawn;
  logic       objectx, objecty, hit, at_left, at_right, at_top, at_bottom;
  logic [9:0] xl, yt;

  sprite_mover #(.COORD_W(10), .TICK_DIV(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .left(left), .right(right), .up(up), .down(down), .respawn(respawn),
    .xstart(xstart), .ystart(ystart), .xdiff(xdiff), .ydiff(ydiff),
    .xspeed(xspeed), .yspeed(yspeed),
    .left_bound(left_bound), .right_bound(right_bound),
    .top_bound(top_bound), .bottom_bound(bottom_bound),
    .objectx(objectx), .objecty(objecty), .hit(hit), .xl(xl), .yt(yt),
    .at_left(at_left), .at_right(at_right), .at_top(at_top), .at_bottom(at_bottom)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int flags();
    return int'({at_left, at_right, at_top, at_bottom});
  endfunction

  typedef struct {
    bit       resp, l, r, u, d;
    int       xst, yst, xsp, ysp;
    int       ex, ey;
    bit [3:0] ef;   // {at_left, at_right, at_top, at_bottom}
  } vec_t;

  function automatic vec_t mk(input bit resp, input bit l, input bit r, input bit u, input bit d,
                              input int xst, input int yst, input int xsp, input int ysp,
                              input int ex, input int ey, input bit [3:0] ef);
    vec_t v;
    v.resp = resp; v.l = l; v.r = r; v.u = u; v.d = d;
    v.xst = xst; v.yst = yst; v.xsp = xsp; v.ysp = ysp;
    v.ex = ex; v.ey = ey; v.ef = ef;
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    // Bounds: x in [0,640) with xdiff=32 -> limit 608; y in [10,480) with ydiff=16 -> limit 464.
    vecs[0]  = mk(0, 0,0,0,0, 100,200, 8,5, 100, 200, 4'b0000);
    vecs[1]  = mk(1, 0,1,1,0, 604, 12, 8,5, WR ? 0 : 608, 10, WR ? 4'b1010 : 4'b0110);
    vecs[2]  = mk(0, 0,1,1,0, 604, 12, 8,5, WR ? 8 : 608, 10, WR ? 4'b0010 : 4'b0110);
    vecs[3]  = mk(0, 0,0,0,1, 604, 12, 8,5, WR ? 8 : 608, 15, WR ? 4'b0000 : 4'b0100);
    vecs[4]  = mk(1, 1,1,0,0, 300,200, 8,5, 300, 200, 4'b0000);
    vecs[5]  = mk(0, 1,1,0,0, 300,200, 8,5, 300, 200, 4'b0000);
    vecs[6]  = mk(0, 1,1,0,0, 300,200, 8,5, 300, 200, 4'b0000);
    vecs[7]  = mk(0, 1,0,0,0, 300,200, 8,5, 292, 200, 4'b0000);
    vecs[8]  = mk(0, 0,1,0,1, 300,200, 0,0, 292, 200, 4'b0000);
    vecs[9]  = mk(1, 1,0,0,0,   5,460, 8,5, WR ? 608 : 0, 460, WR ? 4'b0100 : 4'b1000);
    vecs[10] = mk(0, 0,0,0,1,   5,460, 8,5, WR ? 608 : 0, 464, WR ? 4'b0101 : 4'b1001);
    vecs[11] = mk(0, 1,0,1,1,   5,460, 8,5, WR ? 600 : 0, 464, WR ? 4'b0001 : 4'b1001);

    rst = 1'b1; respawn = 1'b0;
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    x = 10'd0; y = 10'd0;
    xstart = 10'd100; ystart = 10'd200; xdiff = 10'd32; ydiff = 10'd16;
    xspeed = 10'd8; yspeed = 10'd5;
    left_bound = 10'd0; right_bound = 10'd640; top_bound = 10'd10; bottom_bound = 10'd480;

    cyc(3);
    chk("reset xl", int'(xl), 0);
    chk("reset yt", int'(yt), 0);
    chk("reset hit", int'({objectx, objecty, hit}), 0);
    chk("reset flags", flags(), 0);

    rst = 1'b0;
    cyc(1);
    chk("load xl", int'(xl), 100);
    chk("load yt", int'(yt), 200);
    chk("load hit forced 0", int'(hit), 0);
    cyc(1);
    chk("pre-tick xl", int'(xl), 100);

    // Each vector starts just after a move edge and ends just after the next one.
    for (int i = 0; i < 12; i++) begin
      xstart  = 10'(vecs[i].xst);  ystart = 10'(vecs[i].yst);
      xspeed  = 10'(vecs[i].xsp);  yspeed = 10'(vecs[i].ysp);
      left    = vecs[i].l; right = vecs[i].r; up = vecs[i].u; down = vecs[i].d;
      respawn = vecs[i].resp;
      cyc(1);
      respawn = 1'b0;
      cyc(3);
      chk($sformatf("vec%0d xl", i), int'(xl), vecs[i].ex);
      chk($sformatf("vec%0d yt", i), int'(yt), vecs[i].ey);
      chk($sformatf("vec%0d flags", i), flags(), int'(vecs[i].ef));
    end

    // Respawn in the same cycle as the tick: reload wins and that tick makes no step.
    left = 1'b0; right = 1'b1; up = 1'b0; down = 1'b0;
    xstart = 10'd50; ystart = 10'd200; xspeed = 10'd8; yspeed = 10'd5;
    cyc(2);
    respawn = 1'b1;
    cyc(1);
    respawn = 1'b0;
    cyc(1);
    chk("respawn+tick xl", int'(xl), 50);
    chk("respawn+tick yt", int'(yt), 200);
    cyc(4);
    chk("step after respawn xl", int'(xl), 58);

    // Hit window: object at (100,200), 16x16.
    right = 1'b0; xdiff = 10'd16; ydiff = 10'd16;
    xstart = 10'd100; ystart = 10'd200;
    respawn = 1'b1;
    cyc(1);
    respawn = 1'b0;
    cyc(3);
    chk("hit setup xl", int'(xl), 100);
    x = 10'd115; y = 10'd215;
    cyc(1);
    chk("hit (115,215)", int'({objectx, objecty, hit}), 3'b111);
    x = 10'd116;
    cyc(1);
    chk("hit (116,215)", int'({objectx, objecty, hit}), 3'b010);
    x = 10'd100; y = 10'd200;
    cyc(1);
    chk("hit (100,200)", int'({objectx, objecty, hit}), 3'b111);
    x = 10'd99; y = 10'd216;
    cyc(1);
    chk("hit (99,216)", int'({objectx, objecty, hit}), 3'b000);

    // Reset asserted while in STEP aborts the move.
    right = 1'b1;
    cyc(3);
    rst = 1'b1;
    #1;
    chk("mid-step rst xl", int'(xl), 0);
    chk("mid-step rst yt", int'(yt), 0);
    chk("mid-step rst hit", int'({objectx, objecty, hit}), 0);
    chk("mid-step rst flags", flags(), 0);
    xstart = 10'd77; ystart = 10'd33; right = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("post-rst xl", int'(xl), 77);
    chk("post-rst yt", int'(yt), 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
